bcd_seq_ctrl: RTL

Sequencing controller for the 8-bit add/subtract BCD display path. On a start pulse it captures two operands and the add/subtract selector, forms a signed-magnitude result, and runs a serial double-dabble conversion to three BCD digits. It then commits the digits plus a sign digit to display registers and continuously time-multiplexes them onto a 4-digit seven-segment display. It replaces free-running combinational conversion with a start/busy/done handshake, so the board top can drive it from debounced buttons.

---
 rtl/bcd_seq_ctrl_pkg.sv | 34 +++
 rtl/bcd_seq_ctrl_if.sv | 21 ++
 rtl/bcd_seq_ctrl_bcd_to_7seg.sv | 27 ++
 rtl/bcd_seq_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequenced BCD add/subtract display path.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [1:0] UNITS    = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;
  localparam logic [1:0] SIGN     = 2'd3;

  localparam int CONV_ITERS = 9;

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
  function automatic logic [11:0] bcd_add3(input logic [11:0] bcd);
    logic [11:0] res;
    res = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// Request/response handshake between the board top and the BCD sequencing controller.
interface bcd_seq_ctrl_if;

  logic       start;
  logic       selector_suma_resta;
  logic [7:0] input_top_1;
  logic [7:0] input_top_2;
  logic       busy;
  logic       done;

  modport master (
    output start, selector_suma_resta, input_top_1, input_top_2,
    input  busy, done
  );

  modport slave (
    input  start, selector_suma_resta, input_top_1, input_top_2,
    output busy, done
  );

endinterface

// File: rtl/bcd_seq_ctrl_bcd_to_7seg.sv
// Active-low seven-segment decode {g,f,e,d,c,b,a}; non-decimal codes are blank.
module bcd_to_7seg
  import bcd_seq_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Start/busy/done controller: signed-magnitude add/subtract, serial double-dabble to
// three BCD digits, and continuous 4-digit multiplexed seven-segment scan.
module bcd_seq_ctrl
  import bcd_seq_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  bcd_seq_ctrl_if.slave    bus,
  output logic [6:0]       SSeg,
  output logic [3:0]       an
);

  localparam int              DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       ITER_LAST = 4'(CONV_ITERS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_busy;
  logic        r_done;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_capture;
  logic        w_iterate;
  logic        w_commit;

  logic [8:0]  w_mag_in;
  logic        w_neg_in;
  logic [8:0]  r_mag;
  logic        r_neg;
  logic [11:0] r_bcd;
  logic [3:0]  r_iter;

  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;
  logic        r_disp_neg;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_slot;
  logic [3:0]       w_nibble;
  logic [6:0]       w_digit_seg;

  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // Signed-magnitude result of the operands currently on the bus
  always_comb begin
    w_mag_in = 9'd0;
    w_neg_in = 1'b0;
    if (!bus.selector_suma_resta) begin
      w_mag_in = {1'b0, bus.input_top_1} + {1'b0, bus.input_top_2};
      w_neg_in = 1'b0;
    end else if (bus.input_top_1 >= bus.input_top_2) begin
      w_mag_in = {1'b0, bus.input_top_1} - {1'b0, bus.input_top_2};
      w_neg_in = 1'b0;
    end else begin
      w_mag_in = {1'b0, bus.input_top_2} - {1'b0, bus.input_top_1};
      w_neg_in = 1'b1;
    end
  end

  // FSM state register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = ST_CONV;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (r_iter == ITER_LAST) begin
          w_next = ST_COMMIT;
        end else begin
          w_next = ST_CONV;
        end
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // FSM outputs; start is only honoured in IDLE, so a busy request never re-samples operands
  always_comb begin
    w_capture = 1'b0;
    w_iterate = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      ST_IDLE:   w_capture = bus.start;
      ST_CONV:   w_iterate = 1'b1;
      ST_COMMIT: w_commit  = 1'b1;
      default:   w_capture = 1'b0;
    endcase
    w_busy_nxt = (w_next != ST_IDLE);
    w_done_nxt = w_commit;
  end

  // Operand capture, conversion shift chain and display commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag      <= 9'd0;
      r_neg      <= 1'b0;
      r_bcd      <= 12'd0;
      r_iter     <= 4'd0;
      r_hund     <= 4'd0;
      r_tens     <= 4'd0;
      r_units    <= 4'd0;
      r_disp_neg <= 1'b0;
    end else begin
      if (w_capture) begin
        r_mag  <= w_mag_in;
        r_neg  <= w_neg_in;
        r_bcd  <= 12'd0;
        r_iter <= 4'd0;
      end else if (w_iterate) begin
        {r_bcd, r_mag} <= {bcd_add3(r_bcd), r_mag} << 1'b1;
        r_iter         <= r_iter + 4'd1;
      end
      if (w_commit) begin
        r_hund     <= r_bcd[11:8];
        r_tens     <= r_bcd[7:4];
        r_units    <= r_bcd[3:0];
        r_disp_neg <= r_neg;
      end
    end
  end

  // Refresh divider and slot index; runs regardless of FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_slot <= UNITS;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Anode select and digit mux for the current slot
  always_comb begin
    an       = 4'b1111;
    w_nibble = 4'd0;
    case (r_slot)
      UNITS:    begin an = 4'b1110; w_nibble = r_units; end
      TENS:     begin an = 4'b1101; w_nibble = r_tens;  end
      HUNDREDS: begin an = 4'b1011; w_nibble = r_hund;  end
      SIGN:     begin an = 4'b0111; w_nibble = 4'd0;    end
      default:  begin an = 4'b1111; w_nibble = 4'd0;    end
    endcase
    if (r_slot == SIGN) begin
      SSeg = r_disp_neg ? SEG_MINUS : SEG_BLANK;
    end else begin
      SSeg = w_digit_seg;
    end
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_nibble),
    .o_seg (w_digit_seg)
  );

endmodule
